// File: rtl/cc_pkg.sv
// Shared constants and types for the cache line-fill path.
// Address split is {tag, index, offset}; a line is BEATS memory beats.
// Beat number is the low part of the data SRAM address.
package cc_pkg;

   localparam int TAG_W  = 18;
   localparam int IDX_W  = 8;
   localparam int OFF_W  = 6;
   localparam int DATA_W = 64;
   localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
   localparam int BEATS  = (2**OFF_W) * 8 / DATA_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int LEN_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INV  = 3'd1,
      ST_REQ  = 3'd2,
      ST_DATA = 3'd3,
      ST_TAG  = 3'd4,
      ST_DONE = 3'd5
   } fill_state_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

   // Line-aligned byte address of a {tag, index} pair.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cc_line_fill.sv
// Purpose: on a tag miss, invalidate the victim, burst-fetch the line into the data SRAM, revalidate the tag, return the requested word.
// Latency: with arready/rvalid always high, tag invalidate 1 cycle after miss, done pulse 12 cycles after miss.
// Backpressure: holds the read request until arready, writes beats only on rvalid; busy_o stalls upstream for the whole fill.
module cc_line_fill
   import cc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    miss_i,
   input  logic [TAG_W-1:0]        tag_i,
   input  logic [IDX_W-1:0]        index_i,
   input  logic [OFF_W-1:0]        offset_i,
   output logic                    busy_o,
   output logic                    mem_arvalid_o,
   input  logic                    mem_arready_i,
   output logic [ADDR_W-1:0]       mem_araddr_o,
   output logic [LEN_W-1:0]        mem_arlen_o,
   input  logic                    mem_rvalid_i,
   output logic                    mem_rready_o,
   input  logic [DATA_W-1:0]       mem_rdata_i,
   input  logic                    mem_rlast_i,
   output logic                    data_wren_o,
   output logic [IDX_W+BEAT_W-1:0] data_waddr_o,
   output logic [DATA_W-1:0]       data_wdata_o,
   output logic                    tag_wren_o,
   output logic [IDX_W-1:0]        tag_waddr_o,
   output logic [TAG_W:0]          tag_wdata_o,
   output logic                    fill_done_o,
   output logic [DATA_W-1:0]       fill_word_o,
   output logic                    err_o
);

   fill_state_t       state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [BEAT_W-1:0] word_sel_q, word_sel_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0] fill_word_q, fill_word_d;
   logic              err_q, err_d;

   logic              beat;
   logic              last_beat;
   tag_entry_t        tag_entry;

   // Only the beat-select bits of the offset matter; the byte-in-word bits are dropped.
   logic              unused_offset_lsbs;
   assign unused_offset_lsbs = ^offset_i[OFF_W-BEAT_W-1:0];

   assign beat      = (state_q == ST_DATA) && mem_rvalid_i;
   assign last_beat = (beat_cnt_q == BEAT_W'(BEATS-1));

   // Next-state: FSM sequencing, miss capture, beat counting, word capture and rlast checking.
   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      index_d     = index_q;
      word_sel_d  = word_sel_q;
      beat_cnt_d  = beat_cnt_q;
      fill_word_d = fill_word_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_i) begin
               tag_d      = tag_i;
               index_d    = index_i;
               word_sel_d = offset_i[OFF_W-1:OFF_W-BEAT_W];
               state_d    = ST_INV;
            end
         end
         ST_INV: begin
            beat_cnt_d = '0;
            state_d    = ST_REQ;
         end
         ST_REQ: begin
            if (mem_arready_i) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               if (beat_cnt_q == word_sel_q) fill_word_d = mem_rdata_i;
               // Our own count decides the end of the line; a disagreeing rlast is only flagged.
               if (mem_rlast_i != last_beat) err_d = 1'b1;
               if (last_beat) state_d = ST_TAG;
            end
         end
         ST_TAG:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; everything not owned by the current state is driven to zero.
   always_comb begin
      busy_o        = (state_q != ST_IDLE);
      mem_arvalid_o = 1'b0;
      mem_araddr_o  = '0;
      mem_arlen_o   = '0;
      mem_rready_o  = 1'b0;
      data_wren_o   = 1'b0;
      data_waddr_o  = '0;
      data_wdata_o  = '0;
      tag_wren_o    = 1'b0;
      tag_waddr_o   = '0;
      tag_entry     = '0;
      fill_done_o   = 1'b0;
      fill_word_o   = '0;
      case (state_q)
         ST_INV: begin
            tag_wren_o      = 1'b1;
            tag_waddr_o     = index_q;
            tag_entry.valid = 1'b0;
            tag_entry.tag   = tag_q;
         end
         ST_REQ: begin
            mem_arvalid_o = 1'b1;
            mem_araddr_o  = line_addr(tag_q, index_q);
            mem_arlen_o   = LEN_W'(BEATS-1);
         end
         ST_DATA: begin
            mem_rready_o = 1'b1;
            if (mem_rvalid_i) begin
               data_wren_o  = 1'b1;
               data_waddr_o = {index_q, beat_cnt_q};
               data_wdata_o = mem_rdata_i;
            end
         end
         ST_TAG: begin
            tag_wren_o      = 1'b1;
            tag_waddr_o     = index_q;
            tag_entry.valid = 1'b1;
            tag_entry.tag   = tag_q;
         end
         ST_DONE: begin
            fill_done_o = 1'b1;
            fill_word_o = fill_word_q;
         end
         default: ;
      endcase
   end

   assign tag_wdata_o = tag_entry;
   assign err_o       = err_q;

   // State registers; reset abandons any fill in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tag_q       <= '0;
         index_q     <= '0;
         word_sel_q  <= '0;
         beat_cnt_q  <= '0;
         fill_word_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         index_q     <= index_d;
         word_sel_q  <= word_sel_d;
         beat_cnt_q  <= beat_cnt_d;
         fill_word_q <= fill_word_d;
         err_q       <= err_d;
      end
   end

endmodule
